// File: rtl/lsu_mem_adapter_pkg.sv
// ============================================================================
// Module      : lsu_mem_adapter_pkg
// Description : Shared types and helpers for the load/store memory adapter:
//               access-size encodings, FSM state encodings, lane-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef HIGH_BIT_TO_FIT
`define HIGH_BIT_TO_FIT(n) ($clog2((n) + 1) - 1)
`endif

package lsu_mem_adapter_pkg;

  // Access size as presented by the core
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  // Adapter FSM; ST_ERR burns one cycle so error responses land one edge
  // after acceptance without touching the memory port
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ0 = 3'd1,
    ST_GAP  = 3'd2,
    ST_REQ1 = 3'd3,
    ST_ERR  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // Width of the byte offset within a 32-bit word
  localparam int unsigned OFF_W = `HIGH_BIT_TO_FIT(3) + 1;

  // Unshifted byte-enable pattern for an access size
  function automatic logic [3:0] size_to_bytes_mask(input size_e sz);
    case (sz)
      SZ_B:    size_to_bytes_mask = 4'b0001;
      SZ_H:    size_to_bytes_mask = 4'b0011;
      default: size_to_bytes_mask = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic: byte-enable mask and write lane
//               across two adjacent words, split detection, and read-data
//               extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_mem_adapter_pkg::*;
(
  input  size_e             size,
  input  logic              uns,
  input  logic [OFF_W-1:0]  off,
  input  logic [31:0]       wdata,
  input  logic [31:0]       lo,
  input  logic [31:0]       hi,
  output logic [7:0]        mask,
  output logic [63:0]       lane,
  output logic              split,
  output logic [31:0]       rdata
);

  logic [31:0] w_shifted;

  // Mask and store lane spread over {word1, word0}; any high-half byte
  // enable means the access crosses into the next word
  always_comb begin
    mask  = {4'b0000, size_to_bytes_mask(size)} << off;
    lane  = {32'd0, wdata} << {off, 3'b000};
    split = |mask[7:4];
  end

  // Realign the two captured words and extend the selected bytes
  always_comb begin
    w_shifted = 32'({hi, lo} >> {off, 3'b000});
    case (size)
      SZ_B:    rdata = uns ? {24'd0, w_shifted[7:0]}
                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    rdata = uns ? {16'd0, w_shifted[15:0]}
                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: rdata = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_adapter.sv
// ============================================================================
// Module      : lsu_mem_adapter
// Description : Load/store adapter between an RV32 core data port and a
//               word-wide single-port memory. Converts sub-word accesses to
//               masked word accesses and splits word-crossing accesses into
//               two sequential memory transactions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_adapter
  import lsu_mem_adapter_pkg::*;
#(
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      r_state;
  state_e      w_state_nxt;

  // Latched request
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  // Captured read words
  logic [31:0] r_lo;
  logic [31:0] r_hi;

  // Registered port outputs
  logic        r_mem_valid;
  logic [3:0]  r_mem_wen;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  // Request view: live inputs while idle, latched copy afterwards
  logic        w_live;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_uns;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_word0;
  logic [31:0] w_word1;
  logic [31:0] w_lo;
  logic [31:0] w_hi;

  logic [7:0]  w_mask;
  logic [63:0] w_lane;
  logic        w_split;
  logic [31:0] w_rdata;
  logic        w_err;

  // Select the request source and the words being returned this cycle
  always_comb begin
    w_live  = (r_state == ST_IDLE);
    w_we    = w_live ? req_we       : r_we;
    w_size  = w_live ? req_size     : r_size;
    w_uns   = w_live ? req_unsigned : r_uns;
    w_addr  = w_live ? req_addr     : r_addr;
    w_wdata = w_live ? req_wdata    : r_wdata;
    w_word0 = {w_addr[31:2], 2'b00};
    w_word1 = w_word0 + 32'd4;
    w_lo    = (r_state == ST_REQ0) ? mem_rdata : r_lo;
    w_hi    = (r_state == ST_REQ1) ? mem_rdata : r_hi;
    w_err   = (w_size == SZ_X) || (w_split && !SUPPORT_MISALIGNED);
  end

  lsu_align u_align (
    .size  (size_e'(w_size)),
    .uns   (w_uns),
    .off   (w_addr[1:0]),
    .wdata (w_wdata),
    .lo    (w_lo),
    .hi    (w_hi),
    .mask  (w_mask),
    .lane  (w_lane),
    .split (w_split),
    .rdata (w_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; GAP waits for the memory to drop ready so a stale
  // ready from the first half is never taken as the second response
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_nxt = w_err ? ST_ERR : ST_REQ0;
      ST_REQ0: if (mem_ready) w_state_nxt = w_split ? ST_GAP : ST_RESP;
      ST_GAP:  if (!mem_ready) w_state_nxt = ST_REQ1;
      ST_REQ1: if (mem_ready) w_state_nxt = ST_RESP;
      ST_ERR:  w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the request on acceptance and capture returned read words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_lo    <= 32'd0;
      r_hi    <= 32'd0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == ST_REQ0 && mem_ready) r_lo <= mem_rdata;
      if (r_state == ST_REQ1 && mem_ready) r_hi <= mem_rdata;
    end
  end

  // Memory port registers, loaded from the state being entered so they are
  // stable for the whole time mem_valid is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_valid <= 1'b0;
      r_mem_wen   <= 4'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_valid <= (w_state_nxt == ST_REQ0) || (w_state_nxt == ST_REQ1);
      r_mem_wen   <= 4'd0;
      if (w_state_nxt == ST_REQ0) begin
        r_mem_addr  <= w_word0;
        r_mem_wdata <= w_lane[31:0];
        r_mem_wen   <= w_we ? w_mask[3:0] : 4'd0;
      end else if (w_state_nxt == ST_REQ1) begin
        r_mem_addr  <= w_word1;
        r_mem_wdata <= w_lane[63:32];
        r_mem_wen   <= w_we ? w_mask[7:4] : 4'd0;
      end
    end
  end

  // Response registers: one-cycle pulse with data only for good loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_resp_valid <= (w_state_nxt == ST_RESP);
      r_resp_err   <= (w_state_nxt == ST_RESP) && (r_state == ST_ERR);
      r_resp_rdata <= ((w_state_nxt == ST_RESP) && (r_state != ST_ERR) && !r_we)
                      ? w_rdata : 32'd0;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign mem_valid  = r_mem_valid;
  assign mem_wen    = r_mem_wen;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_adapter.sv
// ============================================================================
// Module      : tb_lsu_mem_adapter
// Description : Directed self-checking bench for lsu_mem_adapter paired with
//               a 256-word registered-response memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid = 1'b0;
  logic        req_valid_nm = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        req_ready, resp_valid, resp_err, mem_valid;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wen;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  logic        req_ready_nm, resp_valid_nm, resp_err_nm, mem_valid_nm;
  logic [31:0] resp_rdata_nm, mem_addr_nm, mem_wdata_nm;
  logic [3:0]  mem_wen_nm;
  logic        mem_ready_nm = 1'b0;
  logic [31:0] mem_rdata_nm = 32'd0;

  logic [31:0] mem [0:255];

  int          errors = 0;
  int          checks = 0;

  int          lat;
  logic [31:0] got_rdata;
  logic        got_err;
  int          nreq;
  logic [31:0] log_addr [0:3];
  logic [3:0]  log_wen [0:3];
  logic [3:0]  wen_or;
  logic        any_valid;
  logic        prev_v;
  logic        ready_during;
  logic        pulse_extra;

  always #5 clk = ~clk;

  lsu_mem_adapter #(.SUPPORT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  lsu_mem_adapter #(.SUPPORT_MISALIGNED(1'b0)) dut_nm (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_nm), .req_ready(req_ready_nm), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid_nm), .resp_err(resp_err_nm),
    .resp_rdata(resp_rdata_nm), .mem_valid(mem_valid_nm), .mem_ready(mem_ready_nm),
    .mem_wen(mem_wen_nm), .mem_addr(mem_addr_nm), .mem_wdata(mem_wdata_nm),
    .mem_rdata(mem_rdata_nm)
  );

  // Word memory: registers ready and read data one edge after valid,
  // repeating the access for as long as valid stays high
  always @(posedge clk) begin
    if (mem_valid) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[9:2]];
      mem_ready <= 1'b1;
    end else begin
      mem_ready <= 1'b0;
    end
  end

  // Record each new memory request seen on the selected adapter
  task automatic sample_mem(input bit nm);
    logic        v;
    logic [31:0] a;
    logic [3:0]  w;
    v = nm ? mem_valid_nm : mem_valid;
    a = nm ? mem_addr_nm  : mem_addr;
    w = nm ? mem_wen_nm   : mem_wen;
    if (v && !prev_v && nreq < 4) begin
      log_addr[nreq] = a;
      log_wen[nreq]  = w;
      nreq++;
    end
    wen_or    = wen_or | w;
    any_valid = any_valid | v;
    prev_v    = v;
  endtask

  // Issue one request and wait (bounded) for its response; lat counts edges
  // after the accept edge, -1 if no response arrived
  task automatic run_req(input bit nm, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    if (nm) req_valid_nm = 1'b1; else req_valid = 1'b1;
    nreq = 0; wen_or = 4'd0; any_valid = 1'b0; prev_v = 1'b0;
    lat = -1; got_rdata = 32'hxxxxxxxx; got_err = 1'bx;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid_nm = 1'b0;
    ready_during = nm ? req_ready_nm : req_ready;
    sample_mem(nm);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      sample_mem(nm);
      if (nm ? resp_valid_nm : resp_valid) begin
        lat       = n;
        got_rdata = nm ? resp_rdata_nm : resp_rdata;
        got_err   = nm ? resp_err_nm : resp_err;
        break;
      end
    end
    @(posedge clk); #1;
    pulse_extra = nm ? resp_valid_nm : resp_valid;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (mem_wen !== 4'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_port: got wen=%h addr=%h wdata=%h want 0", mem_wen, mem_addr, mem_wdata); end
    checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp: got err=%b rdata=%h want 0", resp_err, resp_rdata); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_store_load_word();
    run_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (nreq !== 1 || log_wen[0] !== 4'hF || log_addr[0] !== 32'h10) begin errors++; $display("FAIL sw_mem_req: got n=%0d wen=%h addr=%h want 1 F 10", nreq, log_wen[0], log_addr[0]); end
    checks++; if (ready_during !== 1'b0) begin errors++; $display("FAIL sw_ready_busy: got %b want 0", ready_during); end
    checks++; if (got_err !== 1'b0 || got_rdata !== 32'd0) begin errors++; $display("FAIL sw_resp: got err=%b rdata=%h want 0 0", got_err, got_rdata); end
    checks++; if (pulse_extra !== 1'b0) begin errors++; $display("FAIL sw_pulse_width: got %b want 0", pulse_extra); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem_word: got %h want deadbeef", mem[4]); end
    run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    checks++; if (got_rdata !== 32'hDEADBEEF || got_err !== 1'b0) begin errors++; $display("FAIL lw_data: got %h err=%b want deadbeef 0", got_rdata, got_err); end
    checks++; if (lat !== 2 || wen_or !== 4'd0) begin errors++; $display("FAIL lw_timing: got lat=%0d wen=%h want 2 0", lat, wen_or); end
  endtask

  task automatic test_load_byte();
    mem[4] = 32'h80FF1234;
    run_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    checks++; if (got_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h want ffffff80", got_rdata); end
    checks++; if (wen_or !== 4'd0 || lat !== 2) begin errors++; $display("FAIL lb_signed_port: got wen=%h lat=%0d want 0 2", wen_or, lat); end
    run_req(1'b0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    checks++; if (got_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", got_rdata); end
    checks++; if (wen_or !== 4'd0) begin errors++; $display("FAIL lbu_wen: got %h want 0", wen_or); end
  endtask

  task automatic test_split_word();
    mem[3] = 32'h0; mem[4] = 32'h0;
    run_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344);
    checks++; if (lat !== 6) begin errors++; $display("FAIL split_sw_latency: got %0d want 6", lat); end
    checks++; if (nreq !== 2) begin errors++; $display("FAIL split_sw_gap: got %0d requests want 2", nreq); end
    checks++; if (log_addr[0] !== 32'hC || log_wen[0] !== 4'b1100) begin errors++; $display("FAIL split_sw_half0: got addr=%h wen=%b want c 1100", log_addr[0], log_wen[0]); end
    checks++; if (log_addr[1] !== 32'h10 || log_wen[1] !== 4'b0011) begin errors++; $display("FAIL split_sw_half1: got addr=%h wen=%b want 10 0011", log_addr[1], log_wen[1]); end
    checks++; if (mem[3] !== 32'h33440000 || mem[4] !== 32'h00001122) begin errors++; $display("FAIL split_sw_mem: got %h %h want 33440000 00001122", mem[3], mem[4]); end
    run_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h0E, 32'h0);
    checks++; if (got_rdata !== 32'h11223344 || lat !== 6) begin errors++; $display("FAIL split_lw: got %h lat=%0d want 11223344 6", got_rdata, lat); end
    checks++; if (nreq !== 2 || wen_or !== 4'd0) begin errors++; $display("FAIL split_lw_port: got n=%0d wen=%h want 2 0", nreq, wen_or); end
  endtask

  task automatic test_split_half();
    mem[0] = 32'hAB000000; mem[1] = 32'h000000CD;
    run_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
    checks++; if (got_rdata !== 32'hFFFFCDAB) begin errors++; $display("FAIL lh_split: got %h want ffffcdab", got_rdata); end
    run_req(1'b0, 1'b0, 2'd1, 1'b1, 32'h3, 32'h0);
    checks++; if (got_rdata !== 32'h0000CDAB) begin errors++; $display("FAIL lhu_split: got %h want 0000cdab", got_rdata); end
    // top-of-address-space half store wraps its second word to 0x0
    mem[255] = 32'h0;
    run_req(1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF);
    checks++; if (log_addr[0] !== 32'hFFFFFFFC || log_addr[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h %h want fffffffc 0", log_addr[0], log_addr[1]); end
    checks++; if (mem[255] !== 32'hEF000000 || mem[0] !== 32'hAB0000BE) begin errors++; $display("FAIL wrap_mem: got %h %h want ef000000 ab0000be", mem[255], mem[0]); end
  endtask

  task automatic test_errors();
    run_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h1, 32'h0);
    checks++; if (got_err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL nm_misalign: got err=%b lat=%0d want 1 1", got_err, lat); end
    checks++; if (got_rdata !== 32'd0 || any_valid !== 1'b0) begin errors++; $display("FAIL nm_misalign_port: got rdata=%h valid=%b want 0 0", got_rdata, any_valid); end
    run_req(1'b1, 1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
    checks++; if (got_err !== 1'b1 || lat !== 1 || any_valid !== 1'b0) begin errors++; $display("FAIL nm_size3: got err=%b lat=%0d valid=%b want 1 1 0", got_err, lat, any_valid); end
    run_req(1'b0, 1'b1, 2'd3, 1'b0, 32'h8, 32'h5);
    checks++; if (got_err !== 1'b1 || lat !== 1 || got_rdata !== 32'd0) begin errors++; $display("FAIL size3: got err=%b lat=%0d rdata=%h want 1 1 0", got_err, lat, got_rdata); end
    checks++; if (any_valid !== 1'b0 || pulse_extra !== 1'b0) begin errors++; $display("FAIL size3_port: got valid=%b extra=%b want 0 0", any_valid, pulse_extra); end
  endtask

  task automatic test_reset_in_gap();
    logic seen_resp;
    mem[3] = 32'h0; mem[4] = 32'h55555555;
    seen_resp = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0E; req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL gap_state: got valid=%b ready=%b want 0 0", mem_valid, req_ready); end
    #1 rst = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL gap_reset_now: got valid=%b ready=%b want 0 1", mem_valid, req_ready); end
    repeat (2) begin @(posedge clk); #1; seen_resp = seen_resp | resp_valid; end
    @(negedge clk); rst = 1'b1;
    repeat (8) begin @(posedge clk); #1; seen_resp = seen_resp | resp_valid | mem_valid; end
    checks++; if (seen_resp !== 1'b0) begin errors++; $display("FAIL gap_no_resp: got activity=%b want 0", seen_resp); end
    checks++; if (mem[3] !== 32'h33440000 || mem[4] !== 32'h55555555) begin errors++; $display("FAIL gap_mem: got %h %h want 33440000 55555555", mem[3], mem[4]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_store_load_word();
    test_load_byte();
    test_split_word();
    test_split_half();
    test_errors();
    test_reset_in_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
- Load/store stage directly upstream of the word-wide single-port memory; consumes RV32 core data requests and drives the memory's valid/ready/wen/addr/wdata/rdata port.
- Converts byte/half/word accesses to word accesses with byte-lane enables; shifts write data into lanes; extracts and sign/zero-extends read data.
- Splits misaligned accesses that span a word boundary into two sequential word accesses.

Parameters:
- SUPPORT_MISALIGNED, 1: 1 = split word-spanning accesses; 0 = return error, no memory access.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  adapter can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; illegal size or unsupported misalign
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_valid  out  1  memory request
- mem_ready  in  1  memory response, registered by memory one edge after valid
- mem_wen  out  4  byte-lane write enables; 0 for loads
- mem_addr  out  32  word-aligned address, bits[1:0] = 0
- mem_wdata  out  32  lane-shifted store data
- mem_rdata  in  32  memory read word

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready = 1. Takes effect immediately while rst = 0.
- Accept: request taken on an edge with req_valid & req_ready. All request fields latched.
- Lane math:
  - off = addr[1:0]; nbytes = 1/2/4.
  - 8-bit mask = ((1<<nbytes)-1) << off.
  - 64-bit write lane = wdata << (8*off).
  - Low 32 bits / low 4 mask bits go to word0; high halves go to word1.
  - split = (off + nbytes > 4), i.e. half at off 3, or word at off 1..3.
- Addresses: word0 = {addr[31:2], 2'b00}; word1 = word0 + 4, mod 2^32 (0xFFFFFFFC wraps to 0x0).
- FSM states:
  - IDLE: if size == 3, or (split and SUPPORT_MISALIGNED = 0), go to RESP with err = 1 and no memory access. Otherwise go to REQ0.
  - REQ0: mem_valid = 1, addr = word0, wen = low mask if store. On mem_ready = 1: capture mem_rdata to lo, drop mem_valid, go to GAP if split, else RESP.
  - GAP: mem_valid = 0. Wait for mem_ready = 0, then go to REQ1. Mandatory, so a stale ready is never taken as the second response.
  - REQ1: addr = word1, wen = high mask. On mem_ready = 1: capture to hi, go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Memory port rules:
  - mem_* outputs are registered and held stable while mem_valid = 1.
  - The memory repeats the access while valid stays high. A repeat is idempotent because address and data are unchanged.
- Read: {hi, lo} >> (8*off); take the low nbytes; extend per req_unsigned.
- Latency, counted from the accept edge E0:
  - Aligned: resp_valid high after E2.
  - Split: resp_valid high after E6 (assumes the memory drops ready one edge after valid falls).
  - Error: resp_valid high after E1.
- No pipelining: one transaction in flight; req_ready = 0 from acceptance until back in IDLE.
- Reset mid-transaction: transaction abandoned with no response. A split store already past REQ0 leaves word0 written and word1 untouched.

Decomposition:
- Shared defines header: size encodings (SZ_B/SZ_H/SZ_W), FSM state encodings, existing HIGH_BIT_TO_FIT macro.
- Sub-module lsu_align: purely combinational. Mask/lane generation, split detect, read-data extract/extend.
- FSM and registers stay in lsu_mem_adapter.

Test Plan (bench pairs the adapter with the existing word memory, WORDS = 256):
- Store word 0xDEADBEEF @0x10, then load word @0x10:
  - Store: mem_wen = 4'hF, mem_addr = 0x10, resp_valid after E2.
  - Load: resp_rdata = 0xDEADBEEF, resp_err = 0.
- Word @0x10 = 0x80FF1234; load byte @0x13:
  - Signed: 0xFFFFFF80.
  - Unsigned: 0x00000080.
  - mem_wen = 0 throughout.
- Words @0xC, @0x10 = 0; store word 0x11223344 @0x0E:
  - word@0xC = 0x33440000 (wen 4'b1100), word@0x10 = 0x00001122 (wen 4'b0011).
  - Load word @0x0E returns 0x11223344 after E6; mem_valid low for at least one cycle between halves.
- Word @0x0 = 0xAB000000, word @0x4 = 0x000000CD; load signed half @0x3 -> 0xFFFFCDAB; unsigned -> 0x0000CDAB.
- Error cases:
  - SUPPORT_MISALIGNED = 0, load word @0x1 -> resp_err = 1 after E1, resp_rdata = 0, mem_valid never asserted.
  - req_size = 3 -> same response, either parameter value.
- Pull rst low while in GAP during a split store @0x0E:
  - mem_valid = 0 and req_ready = 1 immediately; no resp_valid.
  - word@0x10 unchanged, word@0xC updated.
